// File: rtl/l2_dir_ctrl.sv
// L2 directory controller: serialises one msg1 request at a time against a
// per-line directory (valid, EXCL/SHARED, owner, sharers, data) and drives msg2.
module l2_dir_ctrl #(
  parameter int unsigned NumLines  = 8,
  parameter int unsigned NumCores  = 4,
  parameter int unsigned DataWidth = 8,
  localparam int unsigned TagWidth  = $clog2(NumLines),
  localparam int unsigned OwnerBits = $clog2(NumCores),
  localparam int unsigned MsgWidth  = 4,
  localparam int unsigned MesiWidth = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MsgWidth-1:0]  msg1_type,
  input  logic [DataWidth-1:0] msg1_data,
  input  logic [TagWidth-1:0]  msg1_tag,
  input  logic [OwnerBits-1:0] msg1_source,
  input  logic [MsgWidth-1:0]  msg3_type,
  input  logic [DataWidth-1:0] msg3_data,
  input  logic [TagWidth-1:0]  msg3_tag,
  input  logic [OwnerBits-1:0] msg3_source,
  output logic [MsgWidth-1:0]  msg2_type,
  output logic [DataWidth-1:0] msg2_data,
  output logic [TagWidth-1:0]  msg2_tag,
  output logic [MesiWidth-1:0] mesi_send,
  output logic [OwnerBits-1:0] cache_owner,
  output logic [NumCores-1:0]  share_list,
  output logic                 busy
);

  // Message encodings
  localparam logic [MsgWidth-1:0] MsgEmpty       = 4'd0;
  localparam logic [MsgWidth-1:0] MsgLoadReq     = 4'd1;
  localparam logic [MsgWidth-1:0] MsgStoreReq    = 4'd2;
  localparam logic [MsgWidth-1:0] MsgWbReq       = 4'd3;
  localparam logic [MsgWidth-1:0] MsgInvAck      = 4'd4;
  localparam logic [MsgWidth-1:0] MsgLoadMemAck  = 4'd5;
  localparam logic [MsgWidth-1:0] MsgStoreMemAck = 4'd6;
  localparam logic [MsgWidth-1:0] MsgDataAck     = 4'd7;
  localparam logic [MsgWidth-1:0] MsgInvFwd      = 4'd8;
  localparam logic [MsgWidth-1:0] MsgLoadMem     = 4'd9;
  localparam logic [MsgWidth-1:0] MsgStoreMem    = 4'd10;

  localparam logic [MesiWidth-1:0] MesiS = 2'd1;
  localparam logic [MesiWidth-1:0] MesiE = 2'd2;
  localparam logic [MesiWidth-1:0] MesiM = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StLookup, StMemWait, StInvWait, StWbWait, StGrant
  } state_e;

  state_e                  state_q, state_d;
  logic [MsgWidth-1:0]     req_type_q, req_type_d;
  logic [TagWidth-1:0]     req_tag_q, req_tag_d;
  logic [DataWidth-1:0]    req_data_q, req_data_d;
  logic [OwnerBits-1:0]    req_src_q, req_src_d;
  logic [NumCores-1:0]     pending_q, pending_d;

  logic [NumLines-1:0]                     valid_q, valid_d;
  logic [NumLines-1:0]                     excl_q, excl_d;
  logic [NumLines-1:0][OwnerBits-1:0]      owner_q, owner_d;
  logic [NumLines-1:0][NumCores-1:0]       sharers_q, sharers_d;
  logic [NumLines-1:0][DataWidth-1:0]      data_q, data_d;

  logic [MsgWidth-1:0]     msg2_type_q, msg2_type_d;
  logic [DataWidth-1:0]    msg2_data_q, msg2_data_d;
  logic [TagWidth-1:0]     msg2_tag_q, msg2_tag_d;
  logic [MesiWidth-1:0]    mesi_send_q, mesi_send_d;
  logic [OwnerBits-1:0]    cache_owner_q, cache_owner_d;
  logic [NumCores-1:0]     share_list_q, share_list_d;
  logic                    busy_q, busy_d;

  // Directory view of the line selected by the latched request
  logic                    line_valid, line_excl;
  logic [OwnerBits-1:0]    line_owner;
  logic [NumCores-1:0]     line_sharers, req_onehot, owner_onehot, others, ack_onehot;
  logic [DataWidth-1:0]    line_data;
  logic                    msg1_known;

  assign line_valid   = valid_q[req_tag_q];
  assign line_excl    = excl_q[req_tag_q];
  assign line_owner   = owner_q[req_tag_q];
  assign line_sharers = sharers_q[req_tag_q];
  assign line_data    = data_q[req_tag_q];
  assign req_onehot   = NumCores'(1) << req_src_q;
  assign owner_onehot = NumCores'(1) << line_owner;
  assign ack_onehot   = NumCores'(1) << msg3_source;
  assign others       = line_sharers & ~req_onehot;
  assign msg1_known   = (msg1_type == MsgLoadReq) || (msg1_type == MsgStoreReq) ||
                        (msg1_type == MsgWbReq);

  // Next-state, directory update and msg2 generation
  always_comb begin
    state_d       = state_q;
    req_type_d    = req_type_q;
    req_tag_d     = req_tag_q;
    req_data_d    = req_data_q;
    req_src_d     = req_src_q;
    pending_d     = pending_q;
    valid_d       = valid_q;
    excl_d        = excl_q;
    owner_d       = owner_q;
    sharers_d     = sharers_q;
    data_d        = data_q;
    msg2_type_d   = MsgEmpty;
    msg2_data_d   = msg2_data_q;
    msg2_tag_d    = msg2_tag_q;
    mesi_send_d   = mesi_send_q;
    cache_owner_d = cache_owner_q;
    share_list_d  = share_list_q;

    case (state_q)
      StIdle: begin
        if (msg1_known) begin
          req_type_d = msg1_type;
          req_tag_d  = msg1_tag;
          req_data_d = msg1_data;
          req_src_d  = msg1_source;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (req_type_q == MsgWbReq) begin
          if (line_valid && line_excl && (line_owner == req_src_q)) begin
            data_d[req_tag_q]    = req_data_q;
            sharers_d[req_tag_q] = line_sharers & ~req_onehot;
            excl_d[req_tag_q]    = 1'b0;
            msg2_type_d          = MsgStoreMem;
            msg2_tag_d           = req_tag_q;
            msg2_data_d          = req_data_q;
            state_d              = StWbWait;
          end else begin
            sharers_d[req_tag_q] = line_sharers & ~req_onehot;
            state_d              = StIdle;
          end
        end else if (!line_valid) begin
          msg2_type_d = MsgLoadMem;
          msg2_tag_d  = req_tag_q;
          state_d     = StMemWait;
        end else if ((req_type_q == MsgLoadReq) && line_excl && (line_owner != req_src_q)) begin
          msg2_type_d  = MsgInvFwd;
          msg2_tag_d   = req_tag_q;
          share_list_d = owner_onehot;
          pending_d    = owner_onehot;
          state_d      = StInvWait;
        end else if ((req_type_q == MsgStoreReq) && (others != '0)) begin
          msg2_type_d  = MsgInvFwd;
          msg2_tag_d   = req_tag_q;
          share_list_d = others;
          pending_d    = others;
          state_d      = StInvWait;
        end else begin
          state_d = StGrant;
        end
      end
      StMemWait: begin
        if ((msg3_type == MsgLoadMemAck) && (msg3_tag == req_tag_q)) begin
          data_d[req_tag_q]    = msg3_data;
          valid_d[req_tag_q]   = 1'b1;
          excl_d[req_tag_q]    = 1'b0;
          sharers_d[req_tag_q] = '0;
          state_d              = StGrant;
        end
      end
      StInvWait: begin
        if ((msg3_type == MsgInvAck) && (msg3_tag == req_tag_q) &&
            ((pending_q & ack_onehot) != '0)) begin
          pending_d = pending_q & ~ack_onehot;
          // The EXCL owner may hold dirty data; its ack carries the latest copy
          if (line_excl && (line_owner == msg3_source)) begin
            data_d[req_tag_q] = msg3_data;
          end
          if ((pending_q & ~ack_onehot) == '0) begin
            state_d = StGrant;
          end
        end
      end
      StGrant: begin
        msg2_type_d   = MsgDataAck;
        msg2_tag_d    = req_tag_q;
        msg2_data_d   = line_data;
        cache_owner_d = req_src_q;
        if (req_type_q == MsgStoreReq) begin
          mesi_send_d          = MesiM;
          excl_d[req_tag_q]    = 1'b1;
          owner_d[req_tag_q]   = req_src_q;
          sharers_d[req_tag_q] = req_onehot;
          share_list_d         = req_onehot;
        end else begin
          mesi_send_d          = (others == '0) ? MesiE : MesiS;
          excl_d[req_tag_q]    = (others == '0);
          if (others == '0) begin
            owner_d[req_tag_q] = req_src_q;
          end
          sharers_d[req_tag_q] = line_sharers | req_onehot;
          share_list_d         = line_sharers | req_onehot;
        end
        state_d = StIdle;
      end
      StWbWait: begin
        if (msg3_type == MsgStoreMemAck) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State, directory and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      req_type_q    <= MsgEmpty;
      req_tag_q     <= '0;
      req_data_q    <= '0;
      req_src_q     <= '0;
      pending_q     <= '0;
      valid_q       <= '0;
      excl_q        <= '0;
      owner_q       <= '0;
      sharers_q     <= '0;
      data_q        <= '0;
      msg2_type_q   <= MsgEmpty;
      msg2_data_q   <= '0;
      msg2_tag_q    <= '0;
      mesi_send_q   <= '0;
      cache_owner_q <= '0;
      share_list_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_type_q    <= req_type_d;
      req_tag_q     <= req_tag_d;
      req_data_q    <= req_data_d;
      req_src_q     <= req_src_d;
      pending_q     <= pending_d;
      valid_q       <= valid_d;
      excl_q        <= excl_d;
      owner_q       <= owner_d;
      sharers_q     <= sharers_d;
      data_q        <= data_d;
      msg2_type_q   <= msg2_type_d;
      msg2_data_q   <= msg2_data_d;
      msg2_tag_q    <= msg2_tag_d;
      mesi_send_q   <= mesi_send_d;
      cache_owner_q <= cache_owner_d;
      share_list_q  <= share_list_d;
      busy_q        <= busy_d;
    end
  end

  assign msg2_type   = msg2_type_q;
  assign msg2_data   = msg2_data_q;
  assign msg2_tag    = msg2_tag_q;
  assign mesi_send   = mesi_send_q;
  assign cache_owner = cache_owner_q;
  assign share_list  = share_list_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_l2_dir_ctrl.sv
// Directed bench for l2_dir_ctrl: expected msg2 messages are queued as stimulus
// is driven and popped when the DUT emits a message.
module tb_l2_dir_ctrl;

  localparam logic [3:0] EMPTY = 4'd0, LOAD_REQ = 4'd1, STORE_REQ = 4'd2, WB_REQ = 4'd3;
  localparam logic [3:0] INV_ACK = 4'd4, LOAD_MEM_ACK = 4'd5, STORE_MEM_ACK = 4'd6;
  localparam logic [3:0] DATA_ACK = 4'd7, INV_FWD = 4'd8, LOAD_MEM = 4'd9, STORE_MEM = 4'd10;
  localparam logic [1:0] M_S = 2'd1, M_E = 2'd2, M_M = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] msg1_type = EMPTY, msg3_type = EMPTY;
  logic [7:0] msg1_data = '0, msg3_data = '0;
  logic [2:0] msg1_tag = '0, msg3_tag = '0;
  logic [1:0] msg1_source = '0, msg3_source = '0;
  logic [3:0] msg2_type;
  logic [7:0] msg2_data;
  logic [2:0] msg2_tag;
  logic [1:0] mesi_send;
  logic [1:0] cache_owner;
  logic [3:0] share_list;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] t;
    logic [2:0] tag;
    logic [7:0] data;
    logic [1:0] mesi;
    logic [1:0] own;
    logic [3:0] sl;
  } exp_t;
  exp_t exp_q[$];

  l2_dir_ctrl dut (
    .clk(clk), .rst(rst),
    .msg1_type(msg1_type), .msg1_data(msg1_data), .msg1_tag(msg1_tag),
    .msg1_source(msg1_source),
    .msg3_type(msg3_type), .msg3_data(msg3_data), .msg3_tag(msg3_tag),
    .msg3_source(msg3_source),
    .msg2_type(msg2_type), .msg2_data(msg2_data), .msg2_tag(msg2_tag),
    .mesi_send(mesi_send), .cache_owner(cache_owner), .share_list(share_list),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // msg2 must never carry two messages on consecutive cycles
  logic prev_msg = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_msg <= 1'b0;
    end else begin
      if (msg2_type !== EMPTY) begin
        tests++;
        assert (!prev_msg) else begin
          fails++;
          $error("FAIL msg2_gap: observed=back-to-back expected=EMPTY between messages");
        end
      end
      prev_msg <= (msg2_type !== EMPTY);
    end
  end

  function automatic void push(input logic [3:0] t, input logic [2:0] tag, input logic [7:0] d,
                               input logic [1:0] m, input logic [1:0] o, input logic [3:0] s);
    exp_t e;
    e.t = t; e.tag = tag; e.data = d; e.mesi = m; e.own = o; e.sl = s;
    exp_q.push_back(e);
  endfunction

  // Present one msg1 for a single sampling edge
  task automatic send1(input logic [3:0] t, input logic [2:0] tag, input logic [1:0] src,
                       input logic [7:0] d);
    msg1_type = t; msg1_tag = tag; msg1_source = src; msg1_data = d;
    @(posedge clk); #1;
    msg1_type = EMPTY;
  endtask

  task automatic send3(input logic [3:0] t, input logic [2:0] tag, input logic [1:0] src,
                       input logic [7:0] d);
    msg3_type = t; msg3_tag = tag; msg3_source = src; msg3_data = d;
    @(posedge clk); #1;
    msg3_type = EMPTY;
  endtask

  // Wait (bounded) for the next msg2 message and score it against the queue head
  task automatic wait_msg(input string name, input int budget, output int cycles);
    bit   got;
    exp_t e;
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (msg2_type !== EMPTY) got = 1'b1;
    end
    check({name, ".arrived"}, 32'(got), 32'd1);
    if (got) begin
      check({name, ".queued"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({name, ".type"}, 32'(msg2_type), 32'(e.t));
        check({name, ".tag"}, 32'(msg2_tag), 32'(e.tag));
        if (e.t == DATA_ACK) begin
          check({name, ".data"}, 32'(msg2_data), 32'(e.data));
          check({name, ".mesi"}, 32'(mesi_send), 32'(e.mesi));
          check({name, ".owner"}, 32'(cache_owner), 32'(e.own));
          check({name, ".share_list"}, 32'(share_list), 32'(e.sl));
        end else if (e.t == INV_FWD) begin
          check({name, ".share_list"}, 32'(share_list), 32'(e.sl));
        end else if (e.t == STORE_MEM) begin
          check({name, ".data"}, 32'(msg2_data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic wait_quiet(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (msg2_type !== EMPTY) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.msg2_type", 32'(msg2_type), 32'(EMPTY));
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.msg2_data", 32'(msg2_data), 32'd0);
    check("rst.msg2_tag", 32'(msg2_tag), 32'd0);
    check("rst.mesi", 32'(mesi_send), 32'd0);
    check("rst.owner", 32'(cache_owner), 32'd0);
    check("rst.share_list", 32'(share_list), 32'd0);

    // Miss: LOAD tag 3 from core 1, with a wrong-tag memory ack first
    push(LOAD_MEM, 3'd3, 8'h00, 2'd0, 2'd0, 4'b0000);
    send1(LOAD_REQ, 3'd3, 2'd1, 8'h00);
    wait_msg("miss.load_mem", 10, cyc);
    send3(LOAD_MEM_ACK, 3'd5, 2'd0, 8'hEE);
    wait_quiet("miss.wrong_tag_ignored", 3);
    check("miss.busy_wait", 32'(busy), 32'd1);
    push(DATA_ACK, 3'd3, 8'h5A, M_E, 2'd1, 4'b0010);
    send3(LOAD_MEM_ACK, 3'd3, 2'd0, 8'h5A);
    wait_msg("miss.grant", 10, cyc);

    // LOAD by core 2 on a line EXCL at core 1: forward, stray acks, then downgrade
    push(INV_FWD, 3'd3, 8'h00, 2'd0, 2'd0, 4'b0010);
    send1(LOAD_REQ, 3'd3, 2'd2, 8'h00);
    wait_msg("ld_fwd.inv", 10, cyc);
    send3(INV_ACK, 3'd3, 2'd3, 8'h11);
    send3(INV_ACK, 3'd4, 2'd1, 8'h22);
    wait_quiet("ld_fwd.stray_ignored", 3);
    check("ld_fwd.busy_wait", 32'(busy), 32'd1);
    push(DATA_ACK, 3'd3, 8'h77, M_S, 2'd2, 4'b0110);
    send3(INV_ACK, 3'd3, 2'd1, 8'h77);
    wait_msg("ld_fwd.grant", 10, cyc);

    // STORE by core 2 with sharers 0110: invalidate core 1 only
    push(INV_FWD, 3'd3, 8'h00, 2'd0, 2'd0, 4'b0010);
    send1(STORE_REQ, 3'd3, 2'd2, 8'h00);
    wait_msg("st_inv.inv", 10, cyc);
    push(DATA_ACK, 3'd3, 8'h77, M_M, 2'd2, 4'b0100);
    send3(INV_ACK, 3'd3, 2'd1, 8'h33);
    wait_msg("st_inv.grant", 10, cyc);

    // Writeback from EXCL owner core 2
    push(STORE_MEM, 3'd3, 8'h99, 2'd0, 2'd0, 4'b0000);
    send1(WB_REQ, 3'd3, 2'd2, 8'h99);
    wait_msg("wb.store_mem", 10, cyc);
    check("wb.busy_before_ack", 32'(busy), 32'd1);
    send3(STORE_MEM_ACK, 3'd3, 2'd0, 8'h00);
    @(negedge clk);
    check("wb.busy_after_ack", 32'(busy), 32'd0);

    // Writeback from a non-owner: silent
    send1(WB_REQ, 3'd3, 2'd0, 8'hAB);
    wait_quiet("wb_nonowner.no_msg", 4);
    check("wb_nonowner.busy", 32'(busy), 32'd0);

    // Hit on the written-back line: exclusive grant, fixed latency
    push(DATA_ACK, 3'd3, 8'h99, M_E, 2'd0, 4'b0001);
    send1(LOAD_REQ, 3'd3, 2'd0, 8'h00);
    wait_msg("hit.grant", 10, cyc);
    check("hit.latency", 32'(cyc), 32'd3);

    // Unknown request type is dropped
    send1(4'hF, 3'd1, 2'd1, 8'h00);
    @(negedge clk);
    check("unknown.busy", 32'(busy), 32'd0);
    wait_quiet("unknown.no_msg", 3);

    // Reset during MEM_WAIT aborts and clears the directory
    push(LOAD_MEM, 3'd6, 8'h00, 2'd0, 2'd0, 4'b0000);
    send1(LOAD_REQ, 3'd6, 2'd3, 8'h00);
    wait_msg("rst_mid.load_mem", 10, cyc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid.msg2_type", 32'(msg2_type), 32'(EMPTY));
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.msg2_data", 32'(msg2_data), 32'd0);
    check("rst_mid.share_list", 32'(share_list), 32'd0);
    push(LOAD_MEM, 3'd3, 8'h00, 2'd0, 2'd0, 4'b0000);
    send1(LOAD_REQ, 3'd3, 2'd1, 8'h00);
    wait_msg("rst_mid.remiss", 10, cyc);
    push(DATA_ACK, 3'd3, 8'h42, M_E, 2'd1, 4'b0010);
    send3(LOAD_MEM_ACK, 3'd3, 2'd0, 8'h42);
    wait_msg("rst_mid.grant", 10, cyc);

    check("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
